// File: rtl/lsu_port_arbiter.sv
// lsu_port_arbiter
// Shares the single LSU port between the core pipeline (requester 0) and the
// interrupt context save/restore engine (requester 1). One grant per cycle,
// round-robin on ties, lockable bursts with an idle timeout, a registered
// issue stage that drives the LSU, and a registered response stage.
//
// Handshake: a requester raises rN_req_i with its fields stable and holds
// them until it sees rN_gnt_o=1 in the same cycle. That cycle is the transfer.
// Exactly one rN_rvalid_o pulse follows, two cycles after the grant. There is
// no ready/back-pressure on the response side; responses must be taken as
// they appear.
//
// LOCK_TIMEOUT must be >= 1.
module lsu_port_arbiter #(
   parameter int unsigned LOCK_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        r0_req_i,
   input  logic        r0_we_i,
   input  logic [2:0]  r0_op_i,
   input  logic [31:0] r0_addr_i,
   input  logic [31:0] r0_wdata_i,
   input  logic        r0_lock_i,
   output logic        r0_gnt_o,
   output logic        r0_rvalid_o,
   output logic [31:0] r0_rdata_o,
   input  logic        r1_req_i,
   input  logic        r1_we_i,
   input  logic [2:0]  r1_op_i,
   input  logic [31:0] r1_addr_i,
   input  logic [31:0] r1_wdata_i,
   input  logic        r1_lock_i,
   output logic        r1_gnt_o,
   output logic        r1_rvalid_o,
   output logic [31:0] r1_rdata_o,
   output logic        lsu_st_en_o,
   output logic [2:0]  lsu_mem_op_o,
   output logic [31:0] lsu_addr_o,
   output logic [31:0] lsu_st_data_o,
   input  logic [31:0] lsu_ld_data_i,
   output logic        lock_err_o,
   output logic [1:0]  dbg_state_o
);

   localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_LOCK0    = 2'd1,
      ST_LOCK1    = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic             last_q;       // requester granted most recently
   logic [CNT_W-1:0] idle_cnt_q;
   logic             timeout;
   logic             owner_idle;
   logic             gnt0;
   logic             gnt1;
   logic             any_gnt;

   logic             iss_valid_q;
   logic             iss_owner_q;
   logic             iss_we_q;
   logic [2:0]       iss_op_q;
   logic [31:0]      iss_addr_q;
   logic [31:0]      iss_wdata_q;

   logic             rsp_valid_q;
   logic             rsp_owner_q;
   logic [31:0]      rsp_data_q;

   // The lock owner has gone LOCK_TIMEOUT cycles without requesting. This
   // cycle still arbitrates as locked; the lock drops at the next edge.
   assign timeout = (state_q != ST_UNLOCKED) && (idle_cnt_q == CNT_W'(LOCK_TIMEOUT));

   assign owner_idle = ((state_q == ST_LOCK0) && !r0_req_i) ||
                       ((state_q == ST_LOCK1) && !r1_req_i);

   assign any_gnt = gnt0 || gnt1;

   // Lock FSM state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_UNLOCKED;
      else       state_q <= state_d;
   end

   // Lock FSM next state: timeout wins, otherwise the granted access decides
   // whether its owner keeps the port.
   always_comb begin
      state_d = state_q;
      if (timeout)   state_d = ST_UNLOCKED;
      else if (gnt0) state_d = r0_lock_i ? ST_LOCK0 : ST_UNLOCKED;
      else if (gnt1) state_d = r1_lock_i ? ST_LOCK1 : ST_UNLOCKED;
   end

   // Lock FSM outputs: grants (round-robin when unlocked, owner-only when
   // locked) and the timeout error pulse. Nothing is granted during reset.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      lock_err_o = 1'b0;
      if (!rst_i) begin
         lock_err_o = timeout;
         case (state_q)
            ST_LOCK0: gnt0 = r0_req_i;
            ST_LOCK1: gnt1 = r1_req_i;
            default: begin
               if (r0_req_i && r1_req_i) begin
                  gnt0 = last_q;
                  gnt1 = !last_q;
               end else begin
                  gnt0 = r0_req_i;
                  gnt1 = r1_req_i;
               end
            end
         endcase
      end
   end

   assign r0_gnt_o    = gnt0;
   assign r1_gnt_o    = gnt1;
   assign dbg_state_o = state_q;

   // Round-robin pointer follows every grant, locked or not.
   always_ff @(posedge clk_i) begin
      if (rst_i)     last_q <= 1'b1;
      else if (gnt0) last_q <= 1'b0;
      else if (gnt1) last_q <= 1'b1;
   end

   // Idle counter for the lock owner; cleared by any grant or a timeout.
   always_ff @(posedge clk_i) begin
      if (rst_i || timeout || any_gnt) idle_cnt_q <= '0;
      else if (owner_idle)             idle_cnt_q <= idle_cnt_q + CNT_W'(1);
   end

   // Issue stage: capture the granted access so it drives the LSU next cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         iss_valid_q <= 1'b0;
         iss_owner_q <= 1'b0;
         iss_we_q    <= 1'b0;
         iss_op_q    <= 3'b000;
         iss_addr_q  <= '0;
         iss_wdata_q <= '0;
      end else begin
         iss_valid_q <= any_gnt;
         if (any_gnt) begin
            iss_owner_q <= gnt1;
            iss_we_q    <= gnt1 ? r1_we_i    : r0_we_i;
            iss_op_q    <= gnt1 ? r1_op_i    : r0_op_i;
            iss_addr_q  <= gnt1 ? r1_addr_i  : r0_addr_i;
            iss_wdata_q <= gnt1 ? r1_wdata_i : r0_wdata_i;
         end
      end
   end

   assign lsu_st_en_o   = iss_valid_q && iss_we_q;
   assign lsu_mem_op_o  = iss_valid_q ? iss_op_q    : 3'b000;
   assign lsu_addr_o    = iss_valid_q ? iss_addr_q  : 32'h0;
   assign lsu_st_data_o = iss_valid_q ? iss_wdata_q : 32'h0;

   // Response stage: register the LSU load data (zero for stores) for the owner.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_q <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= iss_valid_q;
         rsp_owner_q <= iss_owner_q;
         rsp_data_q  <= (iss_valid_q && !iss_we_q) ? lsu_ld_data_i : 32'h0;
      end
   end

   assign r0_rvalid_o = rsp_valid_q && !rsp_owner_q;
   assign r1_rvalid_o = rsp_valid_q &&  rsp_owner_q;
   assign r0_rdata_o  = r0_rvalid_o ? rsp_data_q : 32'h0;
   assign r1_rdata_o  = r1_rvalid_o ? rsp_data_q : 32'h0;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Bench for lsu_port_arbiter: directed scenarios plus a randomized run
// against a grant-order reference model with a response queue.
module tb_lsu_port_arbiter;

   localparam int TO = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT connections ----------------
   logic        req   [0:1];
   logic        we    [0:1];
   logic [2:0]  op    [0:1];
   logic [31:0] addr  [0:1];
   logic [31:0] wdata [0:1];
   logic        lock  [0:1];
   logic        gnt0, gnt1, rv0, rv1, lock_err, lsu_st_en;
   logic [31:0] rd0, rd1, lsu_addr, lsu_wd, lsu_ld_data;
   logic [2:0]  lsu_op;
   logic [1:0]  dbg_state;

   lsu_port_arbiter #(.LOCK_TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .r0_req_i(req[0]), .r0_we_i(we[0]), .r0_op_i(op[0]), .r0_addr_i(addr[0]),
      .r0_wdata_i(wdata[0]), .r0_lock_i(lock[0]),
      .r0_gnt_o(gnt0), .r0_rvalid_o(rv0), .r0_rdata_o(rd0),
      .r1_req_i(req[1]), .r1_we_i(we[1]), .r1_op_i(op[1]), .r1_addr_i(addr[1]),
      .r1_wdata_i(wdata[1]), .r1_lock_i(lock[1]),
      .r1_gnt_o(gnt1), .r1_rvalid_o(rv1), .r1_rdata_o(rd1),
      .lsu_st_en_o(lsu_st_en), .lsu_mem_op_o(lsu_op), .lsu_addr_o(lsu_addr),
      .lsu_st_data_o(lsu_wd), .lsu_ld_data_i(lsu_ld_data),
      .lock_err_o(lock_err), .dbg_state_o(dbg_state)
   );

   // ---------------- LSU behaviour (shared by the LSU stub and the model) ----
   function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] o);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[int'(off) * 8 +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (o)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] store_word(input logic [31:0] w, input logic [1:0] off,
                                              input logic [2:0] o, input logic [31:0] d);
      logic [31:0] r;
      r = w;
      case (o)
         3'b000:  r[int'(off) * 8 +: 8] = d[7:0];
         3'b001:  if (off[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] init_word(input int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // LSU stub memory: combinational load, store at the edge ending the cycle
   logic [31:0] lsu_mem [0:255];
   logic [31:0] ref_mem [0:255];
   logic        tb_init = 1'b0;
   logic        tb_wr = 1'b0;
   logic [7:0]  tb_wr_idx = 8'h0;
   logic [31:0] tb_wr_data = 32'h0;

   assign lsu_ld_data = load_val(lsu_mem[lsu_addr[9:2]], lsu_addr[1:0], lsu_op);

   always @(posedge clk) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) lsu_mem[i] <= init_word(i);
      end else if (tb_wr) begin
         lsu_mem[tb_wr_idx] <= tb_wr_data;
      end else if (lsu_st_en) begin
         lsu_mem[lsu_addr[9:2]] <= store_word(lsu_mem[lsu_addr[9:2]], lsu_addr[1:0], lsu_op, lsu_wd);
      end
   end

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [33:0] exp_q[$];          // {valid, owner, data}
   int          m_owner, m_idle, m_last;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_req();
      for (int n = 0; n < 2; n++) begin
         req[n] = 1'b0; we[n] = 1'b0; op[n] = 3'b000;
         addr[n] = 32'h0; wdata[n] = 32'h0; lock[n] = 1'b0;
      end
   endtask

   task automatic set_req(input int n, input logic w, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] d, input logic l);
      req[n] = 1'b1; we[n] = w; op[n] = o; addr[n] = a; wdata[n] = d; lock[n] = l;
   endtask

   task automatic mem_init();
      tb_init = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      tick();
      tb_init = 1'b0;
   endtask

   task automatic mem_write(input logic [7:0] idx, input logic [31:0] d);
      tb_wr = 1'b1; tb_wr_idx = idx; tb_wr_data = d;
      ref_mem[idx] = d;
      tick();
      tb_wr = 1'b0;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      set_req(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      set_req(1, 1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({gnt0, gnt1, rv0, rv1, lock_err, lsu_st_en, lsu_op, dbg_state} !== 11'h0 ||
             lsu_addr !== 32'h0 || lsu_wd !== 32'h0 || rd0 !== 32'h0 || rd1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b%b rv=%b%b err=%b st=%b op=%b st=%0d addr=%h wd=%h rd0=%h rd1=%h, required all 0",
                     gnt0, gnt1, rv0, rv1, lock_err, lsu_st_en, lsu_op, dbg_state, lsu_addr, lsu_wd, rd0, rd1);
         end
         tick();
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++; $display("FAIL reset_first_tie: gnt0/gnt1=%b required 10", {gnt0, gnt1});
      end
      tick();
      req[0] = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++; $display("FAIL reset_second: gnt0/gnt1=%b required 01", {gnt0, gnt1});
      end
      tick();
      clr_req();
      drain(3);
   endtask

   task automatic test_single_load();
      mem_write(8'h04, 32'hDEAD_BEEF);
      set_req(0, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++; $display("FAIL load_gnt: gnt0/gnt1=%b required 10", {gnt0, gnt1});
      end
      tick();
      clr_req();
      @(negedge clk);
      checks++;
      if (lsu_addr !== 32'h10 || lsu_op !== 3'b010 || lsu_st_en !== 1'b0 || rv0 !== 1'b0) begin
         errors++;
         $display("FAIL load_issue: addr=%h op=%b st=%b rv0=%b required 00000010 010 0 0",
                  lsu_addr, lsu_op, lsu_st_en, rv0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rv0 !== 1'b1 || rd0 !== 32'hDEAD_BEEF || rv1 !== 1'b0) begin
         errors++; $display("FAIL load_resp: rv0=%b rd0=%h rv1=%b required 1 deadbeef 0", rv0, rd0, rv1);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rv0 !== 1'b0 || rd0 !== 32'h0) begin
         errors++; $display("FAIL load_single_pulse: rv0=%b rd0=%h required 0 0", rv0, rd0);
      end
      tick();
   endtask

   task automatic test_store_then_load();
      set_req(1, 1'b1, 3'b000, 32'h0000_0803, 32'h1234_56A5, 1'b0);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++; $display("FAIL st_gnt: gnt0/gnt1=%b required 01", {gnt0, gnt1});
      end
      tick();
      set_req(1, 1'b0, 3'b100, 32'h0000_0803, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (gnt1 !== 1'b1 || lsu_st_en !== 1'b1 || lsu_addr !== 32'h803 || lsu_op !== 3'b000 ||
          lsu_wd !== 32'h1234_56A5) begin
         errors++;
         $display("FAIL st_issue: gnt1=%b st=%b addr=%h op=%b wd=%h required 1 1 00000803 000 123456a5",
                  gnt1, lsu_st_en, lsu_addr, lsu_op, lsu_wd);
      end
      tick();
      clr_req();
      @(negedge clk);
      checks++;
      if (rv1 !== 1'b1 || rd1 !== 32'h0 || lsu_st_en !== 1'b0 || lsu_op !== 3'b100) begin
         errors++;
         $display("FAIL st_resp: rv1=%b rd1=%h st=%b op=%b required 1 0 0 100", rv1, rd1, lsu_st_en, lsu_op);
      end
      tick();
      @(negedge clk);
      checks++;
      if (rv1 !== 1'b1 || rd1 !== 32'h0000_00A5 || lsu_st_en !== 1'b0 || rv0 !== 1'b0) begin
         errors++;
         $display("FAIL st_ld_resp: rv1=%b rd1=%h st=%b rv0=%b required 1 000000a5 0 0", rv1, rd1, lsu_st_en, rv0);
      end
      tick();
      drain(1);
   endtask

   task automatic test_fairness();
      logic [1:0] exp;
      set_req(0, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
      set_req(1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b0);
      for (int c = 0; c < 8; c++) begin
         if (c >= 6) clr_req();
         @(negedge clk);
         if (c < 6) begin
            exp = (c % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({gnt0, gnt1} !== exp) begin
               errors++; $display("FAIL fair_gnt[%0d]: gnt0/gnt1=%b required %b", c, {gnt0, gnt1}, exp);
            end
         end
         if (c >= 2) begin
            exp = ((c - 2) % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({rv0, rv1} !== exp) begin
               errors++; $display("FAIL fair_rvalid[%0d]: rv0/rv1=%b required %b", c, {rv0, rv1}, exp);
            end
         end
         tick();
      end
      drain(1);
   endtask

   task automatic test_locked_burst();
      logic [31:0] d0;
      d0 = $urandom;
      clr_req();
      set_req(1, 1'b1, 3'b010, 32'h40, d0, 1'b1);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++; $display("FAIL burst_first: gnt0/gnt1=%b required 01", {gnt0, gnt1});
      end
      tick();
      set_req(1, 1'b1, 3'b010, 32'h44, $urandom, 1'b1);
      set_req(0, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++; $display("FAIL burst_second: gnt0/gnt1=%b required 01", {gnt0, gnt1});
      end
      tick();
      set_req(1, 1'b1, 3'b010, 32'h48, $urandom, 1'b0);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++; $display("FAIL burst_last: gnt0/gnt1=%b required 01", {gnt0, gnt1});
      end
      tick();
      req[1] = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b10) begin
         errors++; $display("FAIL burst_release: gnt0/gnt1=%b required 10", {gnt0, gnt1});
      end
      tick();
      clr_req();
      tick();
      @(negedge clk);
      checks++;
      if (rv0 !== 1'b1 || rd0 !== d0) begin
         errors++; $display("FAIL burst_readback: rv0=%b rd0=%h required 1 %h", rv0, rd0, d0);
      end
      tick();
      drain(1);
   endtask

   task automatic test_timeout();
      clr_req();
      set_req(1, 1'b1, 3'b010, 32'h50, $urandom, 1'b1);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++; $display("FAIL to_lock_gnt: gnt0/gnt1=%b required 01", {gnt0, gnt1});
      end
      tick();
      req[1] = 1'b0;
      set_req(0, 1'b0, 3'b010, 32'h50, 32'h0, 1'b0);
      for (int i = 1; i <= TO; i++) begin
         @(negedge clk);
         checks++;
         if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || lock_err !== 1'b0) begin
            errors++;
            $display("FAIL to_idle[%0d]: gnt0=%b gnt1=%b err=%b required 0 0 0", i, gnt0, gnt1, lock_err);
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (lock_err !== 1'b1 || gnt0 !== 1'b0) begin
         errors++; $display("FAIL to_err: err=%b gnt0=%b required 1 0", lock_err, gnt0);
      end
      tick();
      @(negedge clk);
      checks++;
      if (lock_err !== 1'b0 || gnt0 !== 1'b1) begin
         errors++; $display("FAIL to_release: err=%b gnt0=%b required 0 1", lock_err, gnt0);
      end
      tick();
      clr_req();
      drain(3);
   endtask

   task automatic test_reset_mid_lock();
      set_req(1, 1'b1, 3'b010, 32'h54, $urandom, 1'b1);
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== 2'b01) begin
         errors++; $display("FAIL rl_lock_gnt: gnt0/gnt1=%b required 01", {gnt0, gnt1});
      end
      tick();
      req[1] = 1'b0;
      set_req(0, 1'b0, 3'b010, 32'h54, 32'h0, 1'b0);
      for (int c = 1; c <= 7; c++) begin
         rst = (c == 6);
         @(negedge clk);
         checks++;
         if (gnt0 !== (c == 7) || lock_err !== 1'b0) begin
            errors++;
            $display("FAIL rl_cycle[%0d]: gnt0=%b err=%b required %b 0", c, gnt0, lock_err, (c == 7));
         end
         tick();
      end
      clr_req();
      drain(3);
   endtask

   task automatic test_reset_mid_access();
      set_req(0, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b0);
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'b1) begin
         errors++; $display("FAIL ra_gnt: gnt0=%b required 1", gnt0);
      end
      tick();
      clr_req();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (lsu_addr !== 32'h10) begin
         errors++; $display("FAIL ra_issue: lsu_addr=%h required 00000010", lsu_addr);
      end
      tick();
      rst = 1'b0;
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (rv0 !== 1'b0 || rv1 !== 1'b0 || lsu_addr !== 32'h0) begin
            errors++;
            $display("FAIL ra_discard[%0d]: rv0=%b rv1=%b lsu_addr=%h required 0 0 0", c, rv0, rv1, lsu_addr);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic        pend [0:1];
      int          act  [0:1];
      int          g, k;
      logic        exp_err;
      logic [1:0]  exp_g;
      logic [33:0] e;
      logic [31:0] d, a;
      logic        erv0, erv1;
      mem_init();
      rst = 1'b1;
      clr_req();
      tick();
      rst = 1'b0;
      m_owner = -1; m_idle = 0; m_last = 1;
      exp_q.delete();
      exp_q.push_back(34'h0);
      exp_q.push_back(34'h0);
      pend[0] = 1'b0; pend[1] = 1'b0;
      act[0] = 0; act[1] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (cyc % 40 == 0) begin
            for (int n = 0; n < 2; n++) begin
               k = $urandom_range(0, 3);
               act[n] = (k == 0) ? 0 : (k == 1) ? 20 : (k == 2) ? 70 : 100;
            end
         end
         rst = ($urandom_range(0, 199) == 0);
         for (int n = 0; n < 2; n++) begin
            if (!pend[n] && $urandom_range(1, 100) <= act[n]) begin
               we[n] = 1'($urandom_range(0, 1));
               k = $urandom_range(0, we[n] ? 2 : 4);
               op[n] = (k < 3) ? 3'(k) : (k == 3) ? 3'b100 : 3'b101;
               a = 32'($urandom_range(0, 63));
               if (op[n][1:0] == 2'b10) a[1:0] = 2'b00;
               else if (op[n][1:0] == 2'b01) a[0] = 1'b0;
               addr[n] = a;
               wdata[n] = $urandom;
               lock[n] = ($urandom_range(1, 100) <= 30);
               pend[n] = 1'b1;
            end
            req[n] = pend[n];
         end
         // reference arbitration from the current model state
         if (rst) g = -1;
         else if (m_owner >= 0) g = req[m_owner] ? m_owner : -1;
         else if (req[0] && req[1]) g = 1 - m_last;
         else if (req[0]) g = 0;
         else if (req[1]) g = 1;
         else g = -1;
         exp_err = !rst && (m_owner >= 0) && (m_idle == TO);
         exp_g = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;

         @(negedge clk);
         checks++;
         if ({gnt1, gnt0} !== exp_g) begin
            errors++; $display("FAIL rnd_gnt[%0d]: gnt1/gnt0=%b required %b", cyc, {gnt1, gnt0}, exp_g);
         end
         checks++;
         if (lock_err !== exp_err) begin
            errors++; $display("FAIL rnd_lock_err[%0d]: err=%b required %b", cyc, lock_err, exp_err);
         end
         e = exp_q.pop_front();
         erv0 = e[33] && !e[32];
         erv1 = e[33] && e[32];
         checks++;
         if ({rv1, rv0, rd1, rd0} !== {erv1, erv0, (erv1 ? e[31:0] : 32'h0), (erv0 ? e[31:0] : 32'h0)}) begin
            errors++;
            $display("FAIL rnd_resp[%0d]: rv1=%b rv0=%b rd1=%h rd0=%h required rv1=%b rv0=%b data=%h",
                     cyc, rv1, rv0, rd1, rd0, erv1, erv0, e[31:0]);
         end

         // advance the model across the clock edge
         if (g >= 0) begin
            pend[g] = 1'b0;
            if (we[g]) begin
               ref_mem[addr[g][9:2]] = store_word(ref_mem[addr[g][9:2]], addr[g][1:0], op[g], wdata[g]);
               d = 32'h0;
            end else begin
               d = load_val(ref_mem[addr[g][9:2]], addr[g][1:0], op[g]);
            end
            exp_q.push_back({1'b1, (g == 1), d});
            m_last = g;
         end else begin
            exp_q.push_back(34'h0);
         end
         if (rst) begin
            exp_q[0] = 34'h0;
            exp_q[1] = 34'h0;
            m_owner = -1; m_idle = 0; m_last = 1;
         end else if (exp_err) begin
            m_owner = -1; m_idle = 0;
         end else if (g >= 0) begin
            m_owner = lock[g] ? g : -1;
            m_idle = 0;
         end else if (m_owner >= 0) begin
            m_idle++;
         end
         tick();
      end
      rst = 1'b0;
      clr_req();
      drain(3);
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      clr_req();
      mem_init();
      test_reset();
      test_single_load();
      test_store_then_load();
      test_fairness();
      test_locked_burst();
      test_timeout();
      test_reset_mid_lock();
      test_reset_mid_access();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lsu_port_arbiter.md
# lsu_port_arbiter

Two-requester arbiter and sequencer for the single load/store unit port. It shares the LSU between the core pipeline (requester 0) and the interrupt context save/restore engine (requester 1). It grants one access per cycle with round-robin fairness and supports locked bursts so a context save cannot be interleaved. It registers each granted access into an issue stage that drives the LSU, and returns load data one cycle later.

## Interface
- LOCK_TIMEOUT, 16: idle cycles a lock owner may go without requesting before the lock is forcibly released (must be ≥1).
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- rN_req_i  in  1  request from requester N (N=0,1); held with fields stable until granted.
- rN_we_i  in  1  1 = store, 0 = load.
- rN_op_i  in  3  LSU mem_op encoding (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu).
- rN_addr_i  in  32  byte address.
- rN_wdata_i  in  32  store data.
- rN_lock_i  in  1  1 = keep exclusive ownership after this access.
- rN_gnt_o  out  1  request accepted this cycle (combinational).
- rN_rvalid_o  out  1  response valid, one pulse per granted access.
- rN_rdata_o  out  32  load data (sign/zero-extended by LSU); 0 for stores.
- lsu_st_en_o  out  1  LSU store enable.
- lsu_mem_op_o  out  3  LSU mem_op.
- lsu_addr_o  out  32  LSU address.
- lsu_st_data_o  out  32  LSU store data.
- lsu_ld_data_i  in  32  LSU combinational load data.
- lock_err_o  out  1  one-cycle pulse on lock timeout release.

## Operation
- Lock FSM states: UNLOCKED, LOCK0, LOCK1.
- UNLOCKED:
  - If one requester requests, it is granted.
  - If both request, the requester not granted most recently wins. The round-robin pointer `last` resets to 1, so requester 0 wins the first tie.
- LOCKn:
  - Only requester n may be granted; the other requester's gnt stays 0 regardless of its req.
- Transitions on every grant:
  - Granted with lock_i=1 → LOCKn (n = granted requester).
  - Granted with lock_i=0 → UNLOCKED.
  - `last` updates to the granted requester on every grant, locked or not.
- Timeout:
  - In LOCKn, an idle counter increments each cycle rn_req_i=0 and clears on any grant to n.
  - When the counter reaches LOCK_TIMEOUT: FSM → UNLOCKED, lock_err_o pulses for 1 cycle, counter clears.
  - Arbitration in that same cycle still uses LOCKn. The other requester can be granted from the next cycle.
- Issue stage:
  - Registers valid, owner, we, op, addr, wdata from the granted request.
  - valid=1 drives the LSU: lsu_st_en_o=we, lsu_mem_op_o=op, lsu_addr_o=addr, lsu_st_data_o=wdata.
  - valid=0 drives all LSU outputs to 0 (st_en 0, op 000, addr 0, data 0).
- Response stage:
  - On each cycle with issue valid, the arbiter registers rvalid for the issue owner.
  - rdata = lsu_ld_data_i for loads, 0 for stores.
  - The non-owner's rvalid_o/rdata_o are 0.
- At most one gnt_o, at most one rvalid_o high per cycle. The arbiter accepts a new grant every cycle; no back-pressure from the LSU.

## Timing
- Grant at cycle T (combinational from req and FSM state).
- LSU driven during T+1; a store is committed at the rising edge ending T+1.
- rvalid/rdata at T+2.
- Latency 2 cycles; throughput 1 access/cycle.
- Back-to-back stores to the same address: the later grant's data wins. A load granted at T+1 after a store granted at T to the same address returns the stored data.
- Reset values, applied at the rising edge with rst_i=1 and overriding any grant in that cycle:
  - FSM UNLOCKED, last=1, idle counter 0.
  - Issue valid 0; all rvalid_o 0, rdata_o 0, lsu_* 0, lock_err_o 0.
  - gnt_o is 0 while rst_i=1.
- Reset mid-lock or mid-access: pending issue and response are discarded and no rvalid is produced.
- req with gnt low: no state changes except the round-robin/lock rules above.

## Test plan
- Reset: hold rst_i 2 cycles with both reqs high → all gnt/rvalid/lsu_*/lock_err 0. After release, first tie goes to r0.
- Single load: after LSU memory word 0x10 holds 0xDEADBEEF, r0 lw addr 0x0000_0010 → r0_gnt at T; at T+1 lsu_addr_o=0x10, lsu_mem_op_o=010, lsu_st_en_o=0; at T+2 r0_rvalid=1, r0_rdata=0xDEADBEEF.
- Store then load: r1 sb 0xA5 to 0x0000_0803 at T, r1 lbu same address at T+1 → r1_rvalid at T+2 (rdata 0) and at T+3 (rdata 0x0000_00A5). lsu_st_en_o high only during T+1.
- Fairness: both requesting continuously for 6 cycles → grants r0,r1,r0,r1,r0,r1, with rvalids in the same order two cycles later.
- Locked burst: r1 issues 3 sw with lock=1,1,0 while r0 requests continuously → r0_gnt=0 for all 3 r1 grants; r0 granted the cycle after r1's lock=0 grant.
- Timeout: r1 granted with lock=1, then r1_req=0 while r0 requests → lock_err_o pulses after 16 idle cycles, r0_gnt first high the following cycle. Repeat with rst_i asserted mid-lock → FSM UNLOCKED, r0 granted the cycle after reset release, no lock_err_o.
